// File: rtl/pair_op_scheduler.sv
// Shares one external combinational 2-input bit operator among NREQ requesters.
// Words are granted round-robin, evaluated one bit pair per cycle (MSB pair first), and the pair results are ORed.
module pair_op_scheduler #(
    parameter int NREQ   = 2,
    parameter int WORD_W = 4,
    localparam int ID_W  = $clog2(NREQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*WORD_W-1:0] req_data,
    output logic [NREQ-1:0]        req_ready,
    output logic                   op_a,
    output logic                   op_b,
    input  logic                   op_c,
    output logic                   res_valid,
    output logic                   res_data,
    output logic [ID_W-1:0]        res_id,
    input  logic                   res_ready,
    output logic                   busy
);

    localparam int P     = WORD_W / 2;
    localparam int CNT_W = (P > 1) ? $clog2(P) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_next_s;
    logic [WORD_W-1:0]   word_r;
    logic [CNT_W-1:0]    cnt_r;
    logic                acc_r;
    logic [ID_W-1:0]     id_r;
    logic [ID_W-1:0]     rr_ptr_r;
    logic                res_valid_r;
    logic                res_data_r;
    logic [ID_W-1:0]     res_id_r;

    logic [NREQ-1:0]     grant_s;
    logic [ID_W-1:0]     grant_idx_s;
    logic                grant_found_s;
    logic                capture_s;
    logic                last_pair_s;
    logic                accept_s;

    // Round-robin arbiter: first valid requester at or after rr_ptr_r, wrapping.
    always_comb begin
        int idx_v;
        idx_v         = 0;
        grant_s       = '0;
        grant_idx_s   = '0;
        grant_found_s = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx_v = int'(rr_ptr_r) + k;
            if (idx_v >= NREQ) begin
                idx_v = idx_v - NREQ;
            end else begin
                idx_v = idx_v;
            end
            if (!grant_found_s && req_valid[idx_v]) begin
                grant_found_s  = 1'b1;
                grant_s[idx_v] = 1'b1;
                grant_idx_s    = ID_W'(idx_v);
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    // Next-state logic and per-state control strobes.
    always_comb begin
        state_next_s = state_r;
        capture_s    = 1'b0;
        last_pair_s  = 1'b0;
        accept_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (grant_found_s) begin
                    state_next_s = EVAL;
                    capture_s    = 1'b1;
                end else begin
                    state_next_s = IDLE;
                end
            end
            EVAL: begin
                if (cnt_r == '0) begin
                    state_next_s = DONE;
                    last_pair_s  = 1'b1;
                end else begin
                    state_next_s = EVAL;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_next_s = IDLE;
                    accept_s     = 1'b1;
                end else begin
                    state_next_s = DONE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Captured word, pair counter, accumulator and registered result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            word_r      <= '0;
            cnt_r       <= '0;
            acc_r       <= 1'b0;
            id_r        <= '0;
            rr_ptr_r    <= '0;
            res_valid_r <= 1'b0;
            res_data_r  <= 1'b0;
            res_id_r    <= '0;
        end else begin
            if (capture_s) begin
                word_r   <= req_data[grant_idx_s*WORD_W +: WORD_W];
                cnt_r    <= CNT_W'(P - 1);
                acc_r    <= 1'b0;
                id_r     <= grant_idx_s;
                rr_ptr_r <= (grant_idx_s == ID_W'(NREQ - 1)) ? '0 : grant_idx_s + ID_W'(1);
            end else if (state_r == EVAL) begin
                acc_r <= acc_r | op_c;
                if (!last_pair_s) begin
                    cnt_r <= cnt_r - CNT_W'(1);
                end
            end
            // The final pair's result is folded straight into the registered output.
            if (last_pair_s) begin
                res_valid_r <= 1'b1;
                res_data_r  <= acc_r | op_c;
                res_id_r    <= id_r;
            end else if (accept_s) begin
                res_valid_r <= 1'b0;
                res_data_r  <= 1'b0;
                res_id_r    <= '0;
            end
        end
    end

    assign req_ready = (state_r == IDLE) ? grant_s : '0;
    assign op_a      = (state_r == EVAL) ? word_r[{cnt_r, 1'b1}] : 1'b0;
    assign op_b      = (state_r == EVAL) ? word_r[{cnt_r, 1'b0}] : 1'b0;
    assign res_valid = res_valid_r;
    assign res_data  = res_data_r;
    assign res_id    = res_id_r;
    assign busy      = (state_r != IDLE);

endmodule

// File: tb/tb_pair_op_scheduler.sv
// Directed and randomized bench for pair_op_scheduler (NREQ=2, WORD_W=4) with an XOR operator stub.
module tb_pair_op_scheduler;

    logic       clk;
    logic       rst_n;
    logic [1:0] req_valid;
    logic [7:0] req_data;
    logic [1:0] req_ready;
    logic       op_a;
    logic       op_b;
    logic       op_c;
    logic       res_valid;
    logic       res_data;
    logic       res_id;
    logic       res_ready;
    logic       busy;

    int tests;
    int fails;
    int rr_m;

    pair_op_scheduler #(.NREQ(2), .WORD_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_c      (op_c),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_id    (res_id),
        .res_ready (res_ready),
        .busy      (busy)
    );

    assign op_c = op_a ^ op_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: OR over all pairs of (hi bit XOR lo bit).
    function automatic logic word_result(input logic [3:0] w);
        logic r;
        r = 1'b0;
        for (int j = 0; j < 2; j++) r = r | (w[2*j+1] ^ w[2*j]);
        return r;
    endfunction

    // Reference: first valid requester starting from the model pointer.
    function automatic int pick(input logic [1:0] v, input int rr);
        for (int k = 0; k < 2; k++) begin
            if (v[(rr + k) % 2]) return (rr + k) % 2;
        end
        return -1;
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, req_ready, 0);
        chk({tag, "_op_a"}, op_a, 0);
        chk({tag, "_op_b"}, op_b, 0);
        chk({tag, "_res_valid"}, res_valid, 0);
        chk({tag, "_res_data"}, res_data, 0);
        chk({tag, "_res_id"}, res_id, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    // Entered at a negedge in IDLE; returns at the negedge after the result is taken.
    task automatic txn(input logic [1:0] v, input logic [7:0] d, input int eid,
                       input logic eres, input bit hold);
        logic [3:0] w;
        logic [1:0] gexp;
        w         = d[eid*4 +: 4];
        gexp      = 2'b01 << eid;
        req_valid = v;
        req_data  = d;
        res_ready = 1'b1;
        #1;
        chk("grant", req_ready, gexp);
        @(negedge clk);
        if (!hold) req_valid = 2'b00;
        for (int j = 1; j >= 0; j--) begin
            chk("op_a", op_a, w[2*j+1]);
            chk("op_b", op_b, w[2*j]);
            chk("ready_eval", req_ready, 0);
            chk("busy_eval", busy, 1);
            chk("res_valid_eval", res_valid, 0);
            @(negedge clk);
        end
        chk("res_valid", res_valid, 1);
        chk("res_data", res_data, eres);
        chk("res_id", res_id, eid);
        chk("ready_done", req_ready, 0);
        rr_m = (eid + 1) % 2;
        @(negedge clk);
        chk("res_valid_taken", res_valid, 0);
    endtask

    initial begin
        logic [1:0] v;
        logic [7:0] d;
        tests     = 0;
        fails     = 0;
        rr_m      = 0;
        rst_n     = 1'b0;
        req_valid = 2'b00;
        req_data  = 8'h00;
        res_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("post_reset_idle");

        // Basic words: 6 on req0, 5 on req1, then 0xC and 9 on req0.
        txn(2'b01, 8'h06, 0, 1'b1, 1'b0);
        txn(2'b10, 8'h50, 1, 1'b1, 1'b0);
        txn(2'b01, 8'h0C, 0, 1'b0, 1'b0);
        txn(2'b01, 8'h09, 0, 1'b1, 1'b0);

        // Consumer stall in DONE; pointer now favours req1 (word 9).
        req_valid = 2'b11;
        req_data  = 8'h9C;
        res_ready = 1'b0;
        #1;
        chk("stall_grant", req_ready, 2'b10);
        repeat (3) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            chk("stall_valid", res_valid, 1);
            chk("stall_data", res_data, 1);
            chk("stall_id", res_id, 1);
            chk("stall_ready", req_ready, 0);
            @(negedge clk);
        end
        res_ready = 1'b1;
        req_valid = 2'b00;
        @(negedge clk);
        chk("stall_release_valid", res_valid, 0);
        chk("stall_release_busy", busy, 0);

        // Reset in the middle of EVAL aborts the word.
        req_valid = 2'b10;
        req_data  = 8'h50;
        @(negedge clk);
        chk("pre_abort_busy", busy, 1);
        rst_n     = 1'b0;
        req_valid = 2'b00;
        @(negedge clk);
        check_reset_outputs("abort");
        rst_n = 1'b1;
        rr_m  = 0;

        // Both continuously valid: alternation starting at req0 after reset.
        for (int k = 0; k < 4; k++) begin
            txn(2'b11, 8'h9C, k % 2, logic'(k % 2), 1'b1);
        end

        // Idle period.
        req_valid = 2'b00;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("idle_busy", busy, 0);
            chk("idle_ready", req_ready, 0);
            chk("idle_op_a", op_a, 0);
            chk("idle_op_b", op_b, 0);
        end

        // Randomized traffic against the reference model.
        for (int k = 0; k < 40; k++) begin
            v = 2'($urandom_range(0, 3));
            d = 8'($urandom);
            if (v == 2'b00) begin
                req_valid = 2'b00;
                @(negedge clk);
                chk("rand_idle_busy", busy, 0);
                chk("rand_idle_ready", req_ready, 0);
            end else begin
                txn(v, d, pick(v, rr_m), word_result(d[pick(v, rr_m)*4 +: 4]),
                    bit'($urandom_range(0, 1)));
            end
        end

        req_valid = 2'b00;
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
